// File: rtl/memory_arbiter.sv
// Arbitrates one icache and two dcache requesters onto a single RAM port.
// Define ARB_STATS_EN to add the per-requester completed-word counters.
module memory_arbiter #(
  parameter int WAIT_LIMIT = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  input  logic        dREN0,
  input  logic        dWEN0,
  input  logic [31:0] daddr0,
  input  logic [31:0] dstore0,
  output logic        dwait0,
  output logic [31:0] dload0,
  input  logic        dREN1,
  input  logic        dWEN1,
  input  logic [31:0] daddr1,
  input  logic [31:0] dstore1,
  output logic        dwait1,
  output logic [31:0] dload1,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate
`ifdef ARB_STATS_EN
  ,
  output logic [31:0] icount,
  output logic [31:0] dcount0,
  output logic [31:0] dcount1
`endif
);

  typedef enum logic [1:0] {IDLE, GNT_I, GNT_D0, GNT_D1} state_t;

  localparam logic [1:0] RAM_ACCESS = 2'd2;
  localparam logic [2:0] LIMIT      = 3'(WAIT_LIMIT);

  state_t     state;
  state_t     next_state;
  logic       last_d;
  logic [2:0] icnt;
  logic       d0_req;
  logic       d1_req;
  logic       i_promoted;
  logic       ram_access;

  assign d0_req     = dREN0 | dWEN0;
  assign d1_req     = dREN1 | dWEN1;
  assign i_promoted = iREN & (icnt == LIMIT);
  assign ram_access = (ramstate == RAM_ACCESS);

  // State, round-robin pointer and icache starvation counter
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state  <= IDLE;
      last_d <= 1'b1;
      icnt   <= 3'd0;
    end else begin
      state <= next_state;
      if (state == GNT_D0 && next_state != GNT_D0) last_d <= 1'b0;
      if (state == GNT_D1 && next_state != GNT_D1) last_d <= 1'b1;
      if (state == IDLE) begin
        if (next_state == GNT_I)
          icnt <= 3'd0;
        else if ((next_state == GNT_D0 || next_state == GNT_D1) && iREN && icnt < LIMIT)
          icnt <= icnt + 3'd1;
      end
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (i_promoted)          next_state = GNT_I;
        else if (d0_req && d1_req) next_state = last_d ? GNT_D0 : GNT_D1;
        else if (d0_req)         next_state = GNT_D0;
        else if (d1_req)         next_state = GNT_D1;
        else if (iREN)           next_state = GNT_I;
      end
      // The icache gets exactly one word per grant so dcaches are not starved
      GNT_I:   if (!iREN || ram_access) next_state = IDLE;
      GNT_D0:  if (!d0_req) next_state = IDLE;
      GNT_D1:  if (!d1_req) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = 32'd0;
    ramstore = 32'd0;
    iwait    = 1'b1;
    dwait0   = 1'b1;
    dwait1   = 1'b1;
    iload    = 32'd0;
    dload0   = 32'd0;
    dload1   = 32'd0;
    case (state)
      GNT_I: begin
        ramREN  = iREN;
        ramaddr = iaddr;
        iload   = ramload;
        iwait   = ~ram_access;
      end
      GNT_D0: begin
        ramWEN   = dWEN0;
        ramREN   = dREN0 & ~dWEN0;
        ramaddr  = daddr0;
        ramstore = dstore0;
        dload0   = ramload;
        dwait0   = ~ram_access;
      end
      GNT_D1: begin
        ramWEN   = dWEN1;
        ramREN   = dREN1 & ~dWEN1;
        ramaddr  = daddr1;
        ramstore = dstore1;
        dload1   = ramload;
        dwait1   = ~ram_access;
      end
      default: begin
      end
    endcase
  end

`ifdef ARB_STATS_EN
  // A word completes on an ACCESS cycle while the grantee is actually enabled
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      icount  <= 32'd0;
      dcount0 <= 32'd0;
      dcount1 <= 32'd0;
    end else if (ram_access && (ramREN || ramWEN)) begin
      if (state == GNT_I)  icount  <= icount + 32'd1;
      if (state == GNT_D0) dcount0 <= dcount0 + 32'd1;
      if (state == GNT_D1) dcount1 <= dcount1 + 32'd1;
    end
  end
`endif

endmodule
